// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: register offsets, modes,
// FSM states and the CTRL register layout.
package timer_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned CTRL_BITS  = 4;
  localparam int unsigned PRESCALE_W = 16;

  localparam logic [1:0] CTRL_OFF     = 2'd0;
  localparam logic [1:0] PRESET_OFF   = 2'd1;
  localparam logic [1:0] COUNT_OFF    = 2'd2;
  localparam logic [1:0] PRESCALE_OFF = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int unsigned EN_BIT   = 0;
  localparam int unsigned MODE_LSB = 1;
  localparam int unsigned IM_BIT   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Reserved modes (1x) fall back to one-shot.
  function automatic logic mode_is_reload(logic [1:0] mode);
    case (mode)
      MODE_ONESHOT: return 1'b0;
      MODE_RELOAD:  return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Decrement-rate divider for the countdown timer; only built when
// TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
  import timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick_c
);

  logic [PRESCALE_W-1:0] div_q;

  assign tick_c = (div_q == prescale);

  // Divider restarts after each tick and whenever the timer is reloaded or disabled.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      div_q <= '0;
    end else if (run) begin
      div_q <= tick_c ? '0 : div_q + PRESCALE_W'(1);
    end
  end

endmodule
`endif

// File: rtl/countdown_timer.sv
// Memory-mapped 32-bit countdown timer with one-shot / auto-reload modes
// and a level interrupt. Optional prescaler at addr 3 via TIMER_PRESCALE_EN.
module countdown_timer
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  state_t           state_q, state_nxt;
  ctrl_t            ctrl_q, ctrl_nxt;
  logic [WIDTH-1:0] preset_q, preset_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             int_flag_q, int_flag_nxt;

  logic [1:0] reg_sel;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       step_c;
  logic       unused_addr;

  assign reg_sel     = addr[1:0];
  assign unused_addr = ^addr[29:2];
  assign wr_ctrl     = we && (reg_sel == CTRL_OFF);
  assign wr_preset   = we && (reg_sel == PRESET_OFF);

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  wr_prescale;

  assign wr_prescale = we && (reg_sel == PRESCALE_OFF);

  // Prescale register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q <= '0;
    end else if (wr_prescale) begin
      prescale_q <= din[PRESCALE_W-1:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      ((state_q == LOAD) || !ctrl_q.en),
    .run      (state_q == CNT),
    .prescale (prescale_q),
    .tick_c   (step_c)
  );
`else
  assign step_c = 1'b1;
`endif

  // State and register file update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      int_flag_q <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      ctrl_q     <= ctrl_nxt;
      preset_q   <= preset_nxt;
      count_q    <= count_nxt;
      int_flag_q <= int_flag_nxt;
    end
  end

  // Next-state logic; bus writes to CTRL override the one-shot EN auto-clear.
  always_comb begin
    state_nxt    = state_q;
    ctrl_nxt     = ctrl_q;
    preset_nxt   = preset_q;
    count_nxt    = count_q;
    int_flag_nxt = int_flag_q;

    if (wr_ctrl || wr_preset) begin
      int_flag_nxt = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ctrl_q.en) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        count_nxt = (preset_q == '0) ? WIDTH'(1) : preset_q;
        state_nxt = CNT;
      end
      CNT: begin
        if (!ctrl_q.en) begin
          state_nxt = IDLE;
        end else if (step_c) begin
          if (count_q > WIDTH'(1)) begin
            count_nxt = count_q - WIDTH'(1);
          end else begin
            count_nxt = '0;
            state_nxt = INT;
            if (mode_is_reload(ctrl_q.mode)) begin
              int_flag_nxt = 1'b1;
            end
          end
        end
      end
      INT: begin
        if (mode_is_reload(ctrl_q.mode)) begin
          int_flag_nxt = 1'b0;
          state_nxt    = LOAD;
        end else begin
          int_flag_nxt = 1'b1;
          ctrl_nxt.en  = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_nxt = '{im: din[IM_BIT], mode: din[MODE_LSB +: 2], en: din[EN_BIT]};
    end
    if (wr_preset) begin
      preset_nxt = din;
    end
  end

  // Read mux.
  always_comb begin
    dout = '0;
    case (reg_sel)
      CTRL_OFF:     dout = {{(WIDTH - CTRL_BITS){1'b0}}, ctrl_q};
      PRESET_OFF:   dout = preset_q;
      COUNT_OFF:    dout = count_q;
`ifdef TIMER_PRESCALE_EN
      PRESCALE_OFF: dout = {{(WIDTH - PRESCALE_W){1'b0}}, prescale_q};
`else
      PRESCALE_OFF: dout = '0;
`endif
      default:      dout = '0;
    endcase
  end

  assign irq = int_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// one-shot / auto-reload runs compared against a closed-form timing model.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  countdown_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] data);
    addr = {28'($urandom), sel};
    din  = data;
    we   = 1'b1;
    cycle();
    we   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      addr = 30'(a);
      #1;
      chk($sformatf("%s:rd%0d", tag, a), dout, 32'd0);
    end
    chk({tag, ":irq"}, {31'd0, irq}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    we    = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_zero(tag);
  endtask

  // Model: k = cycles since the enabling CTRL write edge; n = effective preset.
  function automatic logic [31:0] exp_count(bit reload, int unsigned n, int unsigned k,
                                            logic [31:0] prev);
    int unsigned p;
    if (k < 2) return prev;
    if (!reload) return (k - 2 < n) ? 32'(n - (k - 2)) : 32'd0;
    p = (k - 2) % (n + 2);
    return (p < n) ? 32'(n - p) : 32'd0;
  endfunction

  function automatic logic exp_irq(bit reload, bit im, int unsigned n, int unsigned k);
    if (!im || k < 2) return 1'b0;
    if (!reload) return k >= n + 3;
    return ((k - 2) % (n + 2)) == n;
  endfunction

  function automatic logic [31:0] exp_ctrl(bit reload, logic [3:0] c, int unsigned n,
                                           int unsigned k);
    logic [3:0] v;
    v = c;
    if (!reload && k >= n + 3) v[0] = 1'b0;
    return {28'd0, v};
  endfunction

  task automatic check_state(input string tag, input logic [31:0] e_ctrl,
                             input logic [31:0] e_count, input logic e_irq);
    addr = 30'd0;
    #1;
    chk({tag, ":ctrl"}, dout, e_ctrl);
    addr = 30'd2;
    #1;
    chk({tag, ":count"}, dout, e_count);
    chk({tag, ":irq"}, {31'd0, irq}, {31'd0, e_irq});
  endtask

  task automatic check_k(input string tag, input bit rl, input logic [3:0] c,
                         input int unsigned n, input int unsigned k, input logic [31:0] prev);
    check_state($sformatf("%s@%0d", tag, k), exp_ctrl(rl, c, n, k),
                exp_count(rl, n, k, prev), exp_irq(rl, c[3], n, k));
  endtask

  // Optionally write PRESET, then write CTRL and check every cycle up to k=cycles.
  task automatic run_check(input bit wr_pre, input int unsigned n_raw, input logic [3:0] c,
                           input int unsigned cycles, input logic [31:0] prev,
                           input string tag);
    bit          rl;
    int unsigned n;
    rl = (c[2:1] == 2'b01);
    n  = (n_raw == 0) ? 1 : n_raw;
    if (wr_pre) bus_write(2'd1, 32'(n_raw));
    bus_write(2'd0, {28'd0, c});
    for (int k = 0; k <= int'(cycles); k++) begin
      check_k(tag, rl, c, n, k, prev);
      if (k < int'(cycles)) cycle();
    end
  endtask

  initial begin
    logic [3:0] c;
    addr  = '0;
    we    = 1'b0;
    din   = '0;
    reset = 1'b1;
    repeat (2) cycle();

    // Reset values and read-only COUNT.
    do_reset("reset");
    bus_write(2'd2, 32'h55);
    check_zero("count_ro");
`ifndef TIMER_PRESCALE_EN
    bus_write(2'd3, 32'hABCD);
    check_zero("addr3_ro");
`endif
    bus_write(2'd0, 32'hFFFF_FFF0);
    check_zero("ctrl_hi");

    // One-shot with interrupt enabled; irq holds until a CTRL write.
    do_reset("os_rst");
    run_check(1'b1, 5, 4'h9, 12, 32'd0, "oneshot");
    cycle();
    check_state("os_hold", 32'h8, 32'd0, 1'b1);
    bus_write(2'd0, 32'h8);
    check_state("os_clr", 32'h8, 32'd0, 1'b0);
    cycle();
    check_state("os_clr2", 32'h8, 32'd0, 1'b0);

    // Auto-reload: pulses every N+2 cycles.
    do_reset("ar_rst");
    run_check(1'b1, 3, 4'hB, 23, 32'd0, "reload");

    // Masked one-shot: flag set internally, irq low; CTRL write clears flag.
    do_reset("nm_rst");
    run_check(1'b1, 5, 4'h1, 10, 32'd0, "nomask");
    chk("nomask:int_flag", {31'd0, dut.int_flag_q}, 32'd1);
    bus_write(2'd0, 32'h9);
    chk("rearm:int_flag", {31'd0, dut.int_flag_q}, 32'd0);
    for (int k = 0; k <= 10; k++) begin
      check_k("rearm", 1'b0, 4'h9, 5, k, 32'd0);
      if (k < 10) cycle();
    end

    // PRESET write during CNT only affects the next load.
    do_reset("pw_rst");
    run_check(1'b1, 6, 4'h9, 4, 32'd0, "pre");
    bus_write(2'd1, 32'd2);
    for (int k = 5; k <= 12; k++) begin
      check_k("pre", 1'b0, 4'h9, 6, k, 32'd0);
      if (k < 12) cycle();
    end
    run_check(1'b0, 2, 4'h9, 8, 32'd0, "pre_next");

    // Mid-count disable freezes COUNT; re-enable reloads; reset clears all.
    do_reset("mc_rst");
    run_check(1'b1, 32'h20, 4'h9, 18, 32'd0, "mid");
    bus_write(2'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_state("freeze", 32'h0, 32'h0F, 1'b0);
      cycle();
    end
    run_check(1'b0, 32'h20, 4'h9, 27, 32'h0F, "reenable");
    do_reset("mid_reset");

    // Random mode / preset / mask runs, each cut short by a reset.
    for (int t = 0; t < 12; t++) begin
      c = {1'($urandom), 2'($urandom), 1'b1};
      run_check(1'b1, $urandom_range(0, 6), c, $urandom_range(3, 24), 32'd0,
                $sformatf("rnd%0d", t));
      do_reset($sformatf("rnd%0d_rst", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
